// File: rtl/viterbi_traceback.sv
`timescale 1ns/1ps
// Survivor memory plus traceback for the K=7 Viterbi decoder: four banks of TB_LEN decision columns.
// Latency: first decoded bit leaves 2*TB_LEN+2 cycles after the write that completes the newer bank of a pair.
// Backpressure: in_ready drops only at a bank boundary while a second trace is already queued.
module viterbi_traceback #(
  parameter int TB_LEN = 32
) (
  input  logic        clk,
  input  logic        sys_rst,
  input  logic [63:0] dec_in,
  input  logic [5:0]  best_state,
  input  logic        valid_in,
  output logic        in_ready,
  output logic        bit_out,
  output logic        bit_valid,
  output logic        busy
);

  localparam int LG    = $clog2(TB_LEN);
  localparam int AW    = LG + 2;
  localparam int DEPTH = 4 * TB_LEN;

  typedef enum logic {IDLE = 1'b0, TRACE = 1'b1} state_e;

  // Write side
  logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
  logic              first_done_q, first_done_d;
  logic [LG-1:0]     wr_off;
  logic [1:0]        wr_bank;
  logic              wr_en, bank_done, req;

  // Request slots: active (being traced or about to start) and one pending
  logic              act_vld_q, act_vld_d;
  logic [1:0]        act_bank_q, act_bank_d;
  logic [5:0]        act_start_q, act_start_d;
  logic              pend_vld_q, pend_vld_d;
  logic [1:0]        pend_bank_q, pend_bank_d;
  logic [5:0]        pend_start_q, pend_start_d;

  // Traceback engine
  state_e            state_q, state_d;
  logic [AW-1:0]     cnt_q, cnt_d;
  logic [5:0]        tr_state_q, tr_state_d;
  logic [AW-1:0]     rd_addr;
  logic [63:0]       rd_dat_q, rd_dat_d;
  logic [LG-1:0]     idx;
  logic              last_step;
  logic [TB_LEN-1:0] out_q, out_d;

  // Emitter
  logic [TB_LEN-1:0] emit_sr_q, emit_sr_d;
  logic [LG-1:0]     emit_cnt_q, emit_cnt_d;
  logic              bit_out_q, bit_out_d;
  logic              bit_valid_q, bit_valid_d;

  logic [63:0]       mem_q [DEPTH];

  assign wr_off  = wr_ptr_q[LG-1:0];
  assign wr_bank = wr_ptr_q[AW-1:LG];

  // Acceptance, bank completion and trace requests; the very first completion is convergence only.
  always_comb begin
    in_ready     = !(pend_vld_q && (wr_off == '0));
    wr_en        = valid_in && in_ready;
    bank_done    = wr_en && (wr_off == LG'(TB_LEN - 1));
    req          = bank_done && first_done_q;
    wr_ptr_d     = wr_en ? (wr_ptr_q + AW'(1)) : wr_ptr_q;
    first_done_d = first_done_q | bank_done;
  end

  // Read address walks back from the newest column of the active bank; it depends only on the step count.
  always_comb begin
    rd_addr   = {act_bank_q, {LG{1'b1}}} - cnt_q;
    rd_dat_d  = mem_q[rd_addr];
    idx       = LG'(AW'(2 * TB_LEN) - cnt_q);
    last_step = (cnt_q == AW'(2 * TB_LEN));
  end

  // Traceback FSM, request slot management and emission shift register.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    tr_state_d   = tr_state_q;
    out_d        = out_q;
    act_vld_d    = act_vld_q;
    act_bank_d   = act_bank_q;
    act_start_d  = act_start_q;
    pend_vld_d   = pend_vld_q;
    pend_bank_d  = pend_bank_q;
    pend_start_d = pend_start_q;

    if (emit_cnt_q != '0) begin
      bit_out_d   = emit_sr_q[0];
      bit_valid_d = 1'b1;
      emit_sr_d   = emit_sr_q >> 1;
      emit_cnt_d  = emit_cnt_q - LG'(1);
    end else begin
      bit_out_d   = 1'b0;
      bit_valid_d = 1'b0;
      emit_sr_d   = emit_sr_q;
      emit_cnt_d  = emit_cnt_q;
    end

    case (state_q)
      IDLE: begin
        if (act_vld_q) begin
          state_d    = TRACE;
          cnt_d      = '0;
          tr_state_d = act_start_q;
          if (req) begin
            pend_vld_d   = 1'b1;
            pend_bank_d  = wr_bank;
            pend_start_d = best_state;
          end
        end else if (req) begin
          act_vld_d   = 1'b1;
          act_bank_d  = wr_bank;
          act_start_d = best_state;
        end
      end
      TRACE: begin
        cnt_d = cnt_q + AW'(1);
        // cnt_q-1 is the step whose column is in rd_dat_q this cycle
        if (cnt_q != '0) begin
          tr_state_d = {tr_state_q[4:0], rd_dat_q[tr_state_q]};
          if (cnt_q > AW'(TB_LEN)) begin
            out_d[idx] = tr_state_q[5];
          end
        end
        if (last_step) begin
          // Oldest bit goes straight to bit_out; the rest queue behind it.
          bit_out_d   = out_d[0];
          bit_valid_d = 1'b1;
          emit_sr_d   = out_d >> 1;
          emit_cnt_d  = LG'(TB_LEN - 1);
          if (pend_vld_q) begin
            act_bank_d  = pend_bank_q;
            act_start_d = pend_start_q;
            tr_state_d  = pend_start_q;
            cnt_d       = '0;
            pend_vld_d  = 1'b0;
            if (req) begin
              pend_vld_d   = 1'b1;
              pend_bank_d  = wr_bank;
              pend_start_d = best_state;
            end
          end else if (req) begin
            // Request lands in the slot freed this very cycle.
            act_bank_d  = wr_bank;
            act_start_d = best_state;
            tr_state_d  = best_state;
            cnt_d       = '0;
          end else begin
            act_vld_d = 1'b0;
            state_d   = IDLE;
          end
        end else if (req) begin
          pend_vld_d   = 1'b1;
          pend_bank_d  = wr_bank;
          pend_start_d = best_state;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Survivor memory write port and registered read port; contents are never cleared.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[wr_ptr_q] <= dec_in;
    end
    rd_dat_q <= rd_dat_d;
  end

  // Control and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (sys_rst) begin
      wr_ptr_q     <= '0;
      first_done_q <= 1'b0;
      act_vld_q    <= 1'b0;
      act_bank_q   <= '0;
      act_start_q  <= '0;
      pend_vld_q   <= 1'b0;
      pend_bank_q  <= '0;
      pend_start_q <= '0;
      state_q      <= IDLE;
      cnt_q        <= '0;
      tr_state_q   <= '0;
      out_q        <= '0;
      emit_sr_q    <= '0;
      emit_cnt_q   <= '0;
      bit_out_q    <= 1'b0;
      bit_valid_q  <= 1'b0;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      first_done_q <= first_done_d;
      act_vld_q    <= act_vld_d;
      act_bank_q   <= act_bank_d;
      act_start_q  <= act_start_d;
      pend_vld_q   <= pend_vld_d;
      pend_bank_q  <= pend_bank_d;
      pend_start_q <= pend_start_d;
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      tr_state_q   <= tr_state_d;
      out_q        <= out_d;
      emit_sr_q    <= emit_sr_d;
      emit_cnt_q   <= emit_cnt_d;
      bit_out_q    <= bit_out_d;
      bit_valid_q  <= bit_valid_d;
    end
  end

  assign bit_out   = bit_out_q;
  assign bit_valid = bit_valid_q;
  assign busy      = (state_q == TRACE);

endmodule

// File: tb/tb_viterbi_traceback.sv
`timescale 1ns/1ps
// Bench for viterbi_traceback: decision columns follow a known trellis path, so the
// decoded stream must reproduce the input bits one bank late; a scoreboard queue holds them.
module tb_viterbi_traceback;

  localparam int TB = 32;

  logic        clk = 1'b0;
  logic        sys_rst = 1'b1;
  logic [63:0] dec_in = '0;
  logic [5:0]  best_state = '0;
  logic        valid_in = 1'b0;
  logic        in_ready, bit_out, bit_valid, busy;

  int n_vec = 0;
  int n_err = 0;
  int n_emit = 0;
  int n_stall = 0;
  int cyc = 0;
  bit bad_stall = 1'b0;

  logic exp_q[$];
  logic pend_bits[$];
  logic last_bank[$];
  int   col_cnt = 0;
  logic [5:0] ps = '0;
  logic [6:0] prbs = 7'h7F;

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  viterbi_traceback #(.TB_LEN(TB)) dut (
    .clk(clk), .sys_rst(sys_rst), .dec_in(dec_in), .best_state(best_state),
    .valid_in(valid_in), .in_ready(in_ready), .bit_out(bit_out),
    .bit_valid(bit_valid), .busy(busy)
  );

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic next_prbs(output logic u);
    u = prbs[6] ^ prbs[5];
    prbs = {prbs[5:0], u};
  endtask

  // Pops one expected bit for every emitted bit.
  task automatic run_monitor();
    logic e;
    forever begin
      @(negedge clk);
      if (bit_valid === 1'b1) begin
        n_emit++;
        n_vec++;
        if (exp_q.size() == 0) begin
          n_err++;
          $display("FAIL emit_extra: bit_valid=1 bit_out=%b, required bit_valid=0 (no bit expected)", bit_out);
        end else begin
          e = exp_q.pop_front();
          if (bit_out !== e) begin
            n_err++;
            $display("FAIL emit_bit #%0d: bit_out=%b, required %b", n_emit, bit_out, e);
          end
        end
      end
    end
  endtask

  // Presents one column on the true path for input bit u; holds it until accepted.
  task automatic drive_col(input logic u, input bit rnd);
    logic [63:0] d;
    logic [5:0]  s_new;
    bit          rdy, accepted;
    int          waits;
    s_new = {u, ps[5:1]};
    d = rnd ? {$urandom, $urandom} : 64'd0;
    d[s_new] = ps[0];
    dec_in = d;
    best_state = s_new;
    valid_in = 1'b1;
    accepted = 1'b0;
    waits = 0;
    while (!accepted && waits < 300) begin
      rdy = (in_ready === 1'b1);
      if (!rdy) begin
        n_stall++;
        if ((col_cnt % TB) != 0 || busy !== 1'b1 || col_cnt < 2 * TB) bad_stall = 1'b1;
      end
      @(posedge clk);
      #1;
      waits++;
      accepted = rdy;
    end
    valid_in = 1'b0;
    if (!accepted) begin
      n_vec++;
      n_err++;
      $display("FAIL accept_timeout: in_ready=0 for %0d cycles, required 1", waits);
    end else begin
      ps = s_new;
      pend_bits.push_back(u);
      col_cnt++;
      if ((col_cnt % TB) == 0) begin
        if (col_cnt >= 2 * TB) begin
          foreach (last_bank[i]) exp_q.push_back(last_bank[i]);
        end
        last_bank = pend_bits;
        pend_bits.delete();
      end
    end
  endtask

  task automatic clear_model();
    exp_q.delete();
    pend_bits.delete();
    last_bank.delete();
    col_cnt = 0;
    ps = '0;
  endtask

  task automatic do_reset();
    valid_in = 1'b0;
    sys_rst = 1'b1;
    tick(2);
    clear_model();
    sys_rst = 1'b0;
  endtask

  task automatic test_reset();
    int nbusy, nv, s0;
    do_reset();
    n_vec++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL rst_in_ready: got %b, required 1", in_ready); end
    n_vec++; if (bit_out !== 1'b0) begin n_err++; $display("FAIL rst_bit_out: got %b, required 0", bit_out); end
    n_vec++; if (bit_valid !== 1'b0) begin n_err++; $display("FAIL rst_bit_valid: got %b, required 0", bit_valid); end
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL rst_busy: got %b, required 0", busy); end
    nbusy = 0; nv = 0; s0 = n_stall;
    for (int i = 0; i < TB; i++) begin
      drive_col(1'b0, 1'b0);
      if (busy !== 1'b0) nbusy++;
    end
    for (int i = 0; i < 100; i++) begin
      tick(1);
      if (busy !== 1'b0) nbusy++;
      if (bit_valid === 1'b1) nv++;
    end
    n_vec++; if (nbusy != 0) begin n_err++; $display("FAIL first_bank_busy: busy high %0d cycles, required 0", nbusy); end
    n_vec++; if (nv != 0) begin n_err++; $display("FAIL first_bank_valid: bit_valid high %0d cycles, required 0", nv); end
    n_vec++; if (n_stall != s0) begin n_err++; $display("FAIL first_bank_ready: in_ready low %0d cycles, required 0", n_stall - s0); end
  endtask

  task automatic test_all_zero();
    logic b0, b1, b65, b66;
    int first, nv;
    do_reset();
    for (int i = 0; i < 2 * TB; i++) drive_col(1'b0, 1'b0);
    b0 = busy; b1 = 1'b0; b65 = 1'b0; b66 = 1'b1;
    first = -1; nv = 0;
    for (int k = 1; k <= 100; k++) begin
      tick(1);
      if (k == 1) b1 = busy;
      if (k == 65) b65 = busy;
      if (k == 66) b66 = busy;
      if (bit_valid === 1'b1) begin
        if (first < 0) first = k;
        nv++;
      end
    end
    n_vec++; if (b0 !== 1'b0) begin n_err++; $display("FAIL zero_busy_E: got %b, required 0", b0); end
    n_vec++; if (b1 !== 1'b1) begin n_err++; $display("FAIL zero_busy_E1: got %b, required 1", b1); end
    n_vec++; if (b65 !== 1'b1) begin n_err++; $display("FAIL zero_busy_E65: got %b, required 1", b65); end
    n_vec++; if (b66 !== 1'b0) begin n_err++; $display("FAIL zero_busy_E66: got %b, required 0", b66); end
    n_vec++; if (first != 2 * TB + 2) begin n_err++; $display("FAIL zero_first_valid: cycle %0d, required %0d", first, 2 * TB + 2); end
    n_vec++; if (nv != TB) begin n_err++; $display("FAIL zero_valid_len: %0d cycles, required %0d", nv, TB); end
    n_vec++; if (exp_q.size() != 0) begin n_err++; $display("FAIL zero_drain: %0d bits left, required 0", exp_q.size()); end
  endtask

  task automatic test_known_path();
    logic u;
    int e0;
    do_reset();
    e0 = n_emit;
    for (int i = 0; i < 4 * TB; i++) begin
      next_prbs(u);
      drive_col(u, 1'b1);
      if ($urandom_range(0, 7) == 0) tick($urandom_range(1, 3));
    end
    tick(250);
    n_vec++; if (n_emit - e0 != 3 * TB) begin n_err++; $display("FAIL path_count: emitted %0d, required %0d", n_emit - e0, 3 * TB); end
    n_vec++; if (exp_q.size() != 0) begin n_err++; $display("FAIL path_drain: %0d bits left, required 0", exp_q.size()); end
  endtask

  task automatic test_backpressure();
    logic u;
    int e0, s0;
    do_reset();
    e0 = n_emit; s0 = n_stall; bad_stall = 1'b0;
    for (int i = 0; i < 512; i++) begin
      next_prbs(u);
      drive_col(u, 1'b1);
    end
    tick(300);
    n_vec++; if (n_stall - s0 <= 0) begin n_err++; $display("FAIL bp_stall_seen: %0d stall cycles, required >0", n_stall - s0); end
    n_vec++; if (bad_stall !== 1'b0) begin n_err++; $display("FAIL bp_stall_place: in_ready low off a bank boundary or while idle=%b, required 0", bad_stall); end
    n_vec++; if (n_emit - e0 != 512 - TB) begin n_err++; $display("FAIL bp_count: emitted %0d, required %0d", n_emit - e0, 512 - TB); end
    n_vec++; if (exp_q.size() != 0) begin n_err++; $display("FAIL bp_drain: %0d bits left, required 0", exp_q.size()); end
  endtask

  task automatic test_reset_mid_trace();
    logic u;
    int w, nv, e0;
    do_reset();
    for (int i = 0; i < 2 * TB; i++) begin
      next_prbs(u);
      drive_col(u, 1'b1);
    end
    w = 0;
    while (busy !== 1'b1 && w < 20) begin
      tick(1);
      w++;
    end
    n_vec++; if (busy !== 1'b1) begin n_err++; $display("FAIL mid_busy_start: busy=%b after %0d cycles, required 1", busy, w); end
    tick(10);
    sys_rst = 1'b1;
    tick(1);
    n_vec++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL mid_rst_in_ready: got %b, required 1", in_ready); end
    n_vec++; if (bit_valid !== 1'b0) begin n_err++; $display("FAIL mid_rst_bit_valid: got %b, required 0", bit_valid); end
    n_vec++; if (bit_out !== 1'b0) begin n_err++; $display("FAIL mid_rst_bit_out: got %b, required 0", bit_out); end
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL mid_rst_busy: got %b, required 0", busy); end
    clear_model();
    sys_rst = 1'b0;
    nv = 0;
    for (int i = 0; i < TB; i++) begin
      next_prbs(u);
      drive_col(u, 1'b1);
    end
    for (int i = 0; i < 150; i++) begin
      tick(1);
      if (bit_valid === 1'b1) nv++;
    end
    n_vec++; if (nv != 0) begin n_err++; $display("FAIL mid_no_emit: bit_valid high %0d cycles, required 0", nv); end
    e0 = n_emit;
    for (int i = 0; i < TB; i++) begin
      next_prbs(u);
      drive_col(u, 1'b1);
    end
    tick(150);
    n_vec++; if (n_emit - e0 != TB) begin n_err++; $display("FAIL mid_recover: emitted %0d, required %0d", n_emit - e0, TB); end
  endtask

  task automatic test_simultaneous();
    logic u;
    int ce, e0;
    do_reset();
    e0 = n_emit;
    for (int i = 0; i < 2 * TB; i++) begin
      next_prbs(u);
      drive_col(u, 1'b1);
    end
    ce = cyc;
    tick(34);
    for (int i = 0; i < TB; i++) begin
      next_prbs(u);
      drive_col(u, 1'b1);
    end
    n_vec++; if (cyc - ce != 2 * TB + 2) begin n_err++; $display("FAIL sim_align: third bank done at E+%0d, required E+%0d", cyc - ce, 2 * TB + 2); end
    n_vec++; if (busy !== 1'b1) begin n_err++; $display("FAIL sim_restart_busy: got %b, required 1", busy); end
    n_vec++; if (bit_valid !== 1'b1) begin n_err++; $display("FAIL sim_first_emit: got %b, required 1", bit_valid); end
    tick(2 * TB);
    n_vec++; if (bit_valid !== 1'b0) begin n_err++; $display("FAIL sim_gap_valid: got %b, required 0", bit_valid); end
    n_vec++; if (busy !== 1'b1) begin n_err++; $display("FAIL sim_second_busy: got %b, required 1", busy); end
    tick(1);
    n_vec++; if (bit_valid !== 1'b1) begin n_err++; $display("FAIL sim_second_emit: got %b, required 1", bit_valid); end
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL sim_second_idle: got %b, required 0", busy); end
    tick(60);
    n_vec++; if (n_emit - e0 != 2 * TB) begin n_err++; $display("FAIL sim_count: emitted %0d, required %0d", n_emit - e0, 2 * TB); end
    n_vec++; if (exp_q.size() != 0) begin n_err++; $display("FAIL sim_drain: %0d bits left, required 0", exp_q.size()); end
  endtask

  initial begin
    fork
      run_monitor();
      begin
        #2000000;
        $display("FAIL watchdog: time limit reached, required completion");
        $fatal(1, "watchdog");
      end
    join_none
    tick(3);
    test_reset();
    test_all_zero();
    test_known_path();
    test_backpressure();
    test_reset_mid_trace();
    test_simultaneous();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
